// File: rtl/key_debounce.sv
// Serial per-key debounce: each row_sync frame is snapshotted, then walked one
// key per clock against a per-key frame counter, sharing a single comparator.
module key_debounce #(
  parameter int NUM_KEYS        = 103,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS:1]   key_raw,
  input  logic                row_sync,
  output logic [NUM_KEYS:1]   key_down,
  output logic                frame_done,
  output logic                changed,
  output logic                overrun
);

  // state | meaning
  // IDLE  | waiting for row_sync to capture a frame
  // WALK  | processing key idx_q this cycle
  // DONE  | frame_done strobe, changed reports the frame's change flag
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

  localparam int IDX_W = $clog2(NUM_KEYS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_KEYS);
  localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(DEBOUNCE_FRAMES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_KEYS:1]     snap_q, snap_d;
  logic [NUM_KEYS:1]     down_q, down_d;
  logic [CNT_W-1:0]      cnt_q [NUM_KEYS:1];
  logic [CNT_W-1:0]      cnt_d [NUM_KEYS:1];
  logic                  chg_q, chg_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= IDX_W'(1);
      snap_q  <= '0;
      down_q  <= '0;
      chg_q   <= 1'b0;
      for (int k = 1; k <= NUM_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      down_q  <= down_d;
      chg_q   <= chg_d;
      for (int k = 1; k <= NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    down_d  = down_q;
    chg_d   = chg_q;
    for (int k = 1; k <= NUM_KEYS; k++) cnt_d[k] = cnt_q[k];

    case (state_q)
      IDLE: begin
        if (row_sync) begin
          snap_d  = key_raw;
          idx_d   = IDX_W'(1);
          chg_d   = 1'b0;
          state_d = WALK;
        end
      end
      WALK: begin
        // Counter saturates at the terminal count by flipping, so it never wraps.
        if (snap_q[idx_q] == down_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == TERM_CNT) begin
          down_d[idx_q] = snap_q[idx_q];
          cnt_d[idx_q]  = '0;
          chg_d         = 1'b1;
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
        end
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frames arriving outside IDLE (including the DONE->IDLE cycle) are dropped.
  assign overrun    = row_sync && (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign changed    = frame_done && chg_q;
  assign key_down   = down_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed frames plus random bouncing frames, checked
// against a per-key run-length model of the debounce rule.
module tb_key_debounce;
  localparam int NK = 103;
  localparam int DF = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NK:1]   key_raw;
  logic          row_sync;
  logic [NK:1]   key_down;
  logic          frame_done;
  logic          changed;
  logic          overrun;

  int tests = 0;
  int fails = 0;

  // Model: stable value and count of consecutive disagreeing accepted frames.
  bit m_down [1:NK];
  int m_run  [1:NK];
  bit m_chg;

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_FRAMES(DF), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw), .row_sync(row_sync),
    .key_down(key_down), .frame_done(frame_done), .changed(changed),
    .overrun(overrun)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NK:1] rand_vec();
    return NK'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [NK:1] model_vec();
    logic [NK:1] v;
    for (int k = 1; k <= NK; k++) v[k] = m_down[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= NK; k++) begin
      m_down[k] = 1'b0;
      m_run[k]  = 0;
    end
  endtask

  task automatic model_frame(input logic [NK:1] raw);
    m_chg = 1'b0;
    for (int k = 1; k <= NK; k++) begin
      if (raw[k] == m_down[k]) m_run[k] = 0;
      else m_run[k] = m_run[k] + 1;
      if (m_run[k] == DF) begin
        m_down[k] = raw[k];
        m_run[k]  = 0;
        m_chg     = 1'b1;
      end
    end
  endtask

  // One accepted frame; ovr_at (1..104, 0 = none) injects an extra row_sync.
  task automatic frame(input logic [NK:1] raw, input int ovr_at);
    @(negedge clock);
    reset    = 1'b0;
    row_sync = 1'b1;
    key_raw  = raw;
    for (int n = 1; n <= NK + 1; n++) begin
      @(negedge clock);
      row_sync = (n == ovr_at);
      key_raw  = rand_vec();
      #1;
      check("overrun", overrun, (n == ovr_at));
      check("frame_done_timing", frame_done, (n == NK + 1));
      if (n <= NK) check("changed_outside_done", changed, 1'b0);
    end
    model_frame(raw);
    check("key_down", key_down, model_vec());
    check("changed", changed, m_chg);
  endtask

  task automatic frame_with_reset(input logic [NK:1] raw, input int at);
    @(negedge clock);
    row_sync = 1'b1;
    key_raw  = raw;
    for (int n = 1; n <= at; n++) begin
      @(negedge clock);
      row_sync = 1'b0;
      if (n == at) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_key_down", key_down, '0);
    for (int n = 1; n <= NK + 10; n++) begin
      @(negedge clock);
      #1;
      check("no_frame_done_after_abort", frame_done, 1'b0);
    end
    model_reset();
  endtask

  initial begin
    logic [NK:1] r;
    logic [NK:1] target;
    logic [NK:1] b37;
    int pat37 [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

    reset    = 1'b1;
    row_sync = 1'b0;
    key_raw  = '0;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    check("rst_key_down", key_down, '0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_changed", changed, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    repeat (3) frame('0, 0);

    r = '0;
    r[5] = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      frame(r, 0);
      if (f == 3) check("k5_still_low_f3", key_down[5], 1'b0);
      if (f == 4) begin
        check("k5_set_f4", key_down[5], 1'b1);
        check("k5_changed_f4", changed, 1'b1);
      end
      if (f == 5) check("k5_no_change_f5", changed, 1'b0);
    end

    for (int f = 0; f < 8; f++) begin
      b37 = r;
      b37[37] = pat37[f][0];
      frame(b37, 0);
      if (f == 6) check("k37_low_f7", key_down[37], 1'b0);
      if (f == 7) check("k37_high_f8", key_down[37], 1'b1);
    end
    for (int f = 1; f <= 4; f++) begin
      frame(r, 0);
      if (f == 3) check("k37_still_high", key_down[37], 1'b1);
      if (f == 4) check("k37_released", key_down[37], 1'b0);
    end

    r[1]   = 1'b1;
    r[NK]  = 1'b1;
    for (int f = 1; f <= 4; f++) frame(r, 0);
    check("k1_set", key_down[1], 1'b1);
    check("k103_set", key_down[NK], 1'b1);

    r = '0;
    frame(r, 50);
    frame(r, NK + 1);
    frame(r, 0);

    r[10] = 1'b1;
    frame(r, 0);
    frame(r, 0);
    frame_with_reset(r, 60);
    for (int f = 1; f <= 4; f++) begin
      frame(r, 0);
      if (f == 3) check("k10_restart_low", key_down[10], 1'b0);
      if (f == 4) check("k10_restart_high", key_down[10], 1'b1);
    end

    target = rand_vec();
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) target = target ^ (rand_vec() & rand_vec() & rand_vec());
      r = target ^ (rand_vec() & rand_vec() & rand_vec());
      frame(r, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NK + 1)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
